fp_man_addsub_pipe: RTL

//  Two-stage pipelined mantissa add/subtract unit for the FP adder datapath.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_man_addsub_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and width helpers for the FP mantissa datapath.
package fp_pkg;

  localparam int unsigned MAN_WIDTH_DEF = 11;

  // Default-configuration mantissa including hidden, guard and round/sticky bits.
  typedef logic [MAN_WIDTH_DEF+2:0] man_t;

  // Datapath width: mantissa plus hidden, guard and round/sticky bits.
  function automatic int unsigned man_w(input int unsigned man_width);
    return man_width + 3;
  endfunction

  // Width needed to hold a leading-zero count of 0..w.
  function automatic int unsigned lzc_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; count is W for an all-zero value.
module fp_lzc
  import fp_pkg::*;
#(
  parameter  int unsigned W   = 14,
  localparam int unsigned LZW = lzc_w(W)
) (
  input  logic [W-1:0]   value,
  output logic [LZW-1:0] count
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count = LZW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (value[i]) count = LZW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_man_addsub_pipe.sv
// Two-stage pipelined mantissa add/subtract with valid/ready on both sides.
// Stage 1 forms the raw W+1 bit sum/difference; stage 2 fixes the sign and
// registers magnitude, carry, negative and zero flags.
// Optional leading-zero count output: define FP_MAN_LZC_EN.
module fp_man_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int unsigned MAN_WIDTH = 11,
  parameter  int unsigned TAG_WIDTH = 4,
  localparam int unsigned W         = man_w(MAN_WIDTH)
`ifdef FP_MAN_LZC_EN
  ,
  localparam int unsigned LZW       = lzc_w(W)
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         man_higher,
  input  logic [W-1:0]         man_align,
  input  logic                 sub,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_sum,
  output logic                 out_carry,
  output logic                 out_neg,
  output logic                 out_zero,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef FP_MAN_LZC_EN
  ,
  output logic [LZW-1:0]       out_lzc
`endif
);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_en;
  logic                 s2_en;
  logic [W:0]           raw_next;
  logic [W:0]           s1_raw;
  logic                 s1_sub;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [W-1:0]         sum_next;
  logic                 carry_next;
  logic                 neg_next;
  logic                 zero_next;

  // Pipeline enables: a stage loads when empty or when its content moves on.
  always_comb begin
    s2_en    = !s2_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  // Stage 1 arithmetic: two's-complement subtract via inverted operand plus one.
  always_comb begin
    raw_next = {1'b0, man_higher}
             + {1'b0, (sub ? ~man_align : man_align)}
             + {{W{1'b0}}, sub};
  end

  // Stage 1 register: raw result, operation type and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_sub   <= 1'b0;
      s1_tag   <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw <= raw_next;
        s1_sub <= sub;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2 fix-up: for subtraction, bit W clear means the difference went negative.
  always_comb begin
    sum_next   = s1_raw[W-1:0];
    carry_next = 1'b0;
    neg_next   = 1'b0;
    if (!s1_sub) begin
      carry_next = s1_raw[W];
    end else if (!s1_raw[W]) begin
      sum_next = (~s1_raw[W-1:0]) + {{(W-1){1'b0}}, 1'b1};
      neg_next = 1'b1;
    end
    zero_next = (sum_next == '0);
  end

`ifdef FP_MAN_LZC_EN
  logic [LZW-1:0] lzc_next;

  fp_lzc #(.W(W)) u_lzc (
    .value (sum_next),
    .count (lzc_next)
  );

  // Leading-zero count registered alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lzc <= '0;
    end else if (s2_en && s1_valid) begin
      out_lzc <= lzc_next;
    end
  end
`endif

  // Stage 2 / output register; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_neg   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum   <= sum_next;
        out_carry <= carry_next;
        out_neg   <= neg_next;
        out_zero  <= zero_next;
        out_tag   <= s1_tag;
      end
    end
  end

  // Output valid is the stage 2 occupancy flag.
  always_comb begin
    out_valid = s2_valid;
  end

endmodule
